// File: rtl/ysyx_23060061_axi_arbiter.sv
// 2:1 AXI4 arbiter: IFU (read-only) and LSU (read/write) share one master port.
// One transaction in flight at a time; round-robin grant held until the response completes.
module ysyx_23060061_axi_arbiter #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                ID_W   = 4,
  parameter logic [ID_W-1:0]   IFU_ID = ID_W'(0),
  parameter logic [ID_W-1:0]   LSU_ID = ID_W'(1)
) (
  input  logic                 clk,
  input  logic                 rst,

  // IFU read address / data
  input  logic                 ifu_arvalid,
  input  logic [ADDR_W-1:0]    ifu_araddr,
  input  logic [7:0]           ifu_arlen,
  input  logic [2:0]           ifu_arsize,
  input  logic [1:0]           ifu_arburst,
  output logic                 ifu_arready,
  output logic                 ifu_rvalid,
  output logic [DATA_W-1:0]    ifu_rdata,
  output logic [1:0]           ifu_rresp,
  output logic                 ifu_rlast,
  input  logic                 ifu_rready,

  // LSU read address / data
  input  logic                 lsu_arvalid,
  input  logic [ADDR_W-1:0]    lsu_araddr,
  input  logic [7:0]           lsu_arlen,
  input  logic [2:0]           lsu_arsize,
  input  logic [1:0]           lsu_arburst,
  output logic                 lsu_arready,
  output logic                 lsu_rvalid,
  output logic [DATA_W-1:0]    lsu_rdata,
  output logic [1:0]           lsu_rresp,
  output logic                 lsu_rlast,
  input  logic                 lsu_rready,

  // LSU write address / data / response
  input  logic                 lsu_awvalid,
  input  logic [ADDR_W-1:0]    lsu_awaddr,
  input  logic [7:0]           lsu_awlen,
  input  logic [2:0]           lsu_awsize,
  input  logic [1:0]           lsu_awburst,
  output logic                 lsu_awready,
  input  logic                 lsu_wvalid,
  input  logic [DATA_W-1:0]    lsu_wdata,
  input  logic [DATA_W/8-1:0]  lsu_wstrb,
  input  logic                 lsu_wlast,
  output logic                 lsu_wready,
  output logic                 lsu_bvalid,
  output logic [1:0]           lsu_bresp,
  input  logic                 lsu_bready,

  // Master port towards the crossbar
  output logic                 m_arvalid,
  output logic [ADDR_W-1:0]    m_araddr,
  output logic [ID_W-1:0]      m_arid,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  input  logic                 m_arready,
  input  logic                 m_rvalid,
  input  logic [DATA_W-1:0]    m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic [ID_W-1:0]      m_rid,
  output logic                 m_rready,
  output logic                 m_awvalid,
  output logic [ADDR_W-1:0]    m_awaddr,
  output logic [ID_W-1:0]      m_awid,
  output logic [7:0]           m_awlen,
  output logic [2:0]           m_awsize,
  output logic [1:0]           m_awburst,
  input  logic                 m_awready,
  output logic                 m_wvalid,
  output logic [DATA_W-1:0]    m_wdata,
  output logic [DATA_W/8-1:0]  m_wstrb,
  output logic                 m_wlast,
  input  logic                 m_wready,
  input  logic                 m_bvalid,
  input  logic [1:0]           m_bresp,
  input  logic [ID_W-1:0]      m_bid,
  output logic                 m_bready,

  // Current FSM state, for observation only
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_IFU = 2'd1;
  localparam logic [1:0] RD_LSU = 2'd2;
  localparam logic [1:0] WR_LSU = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_grant_lsu;
  logic       ar_done;
  logic       aw_done;
  logic       w_done;

  logic       ifu_req;
  logic       lsu_req;
  logic       grant_ifu;
  logic       grant_lsu;

  logic       ar_hs;
  logic       r_last_hs;
  logic       aw_hs;
  logic       w_last_hs;
  logic       b_hs;

  // Response IDs carry no information here: one transaction is ever outstanding.
  logic       unused_ids;
  assign unused_ids = ^{m_rid, m_bid};

  // Every channel transfers on a cycle where valid & ready are both high at the
  // rising edge; a valid, once raised, is expected to hold until that transfer.
  assign ar_hs     = m_arvalid & m_arready;
  assign r_last_hs = m_rvalid & m_rready & m_rlast;
  assign aw_hs     = m_awvalid & m_awready;
  assign w_last_hs = m_wvalid & m_wready & m_wlast;
  assign b_hs      = m_bvalid & m_bready;

  assign ifu_req   = ifu_arvalid;
  assign lsu_req   = lsu_awvalid | lsu_arvalid;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that was not granted last time wins.
        grant_ifu = ifu_req & (~lsu_req | last_grant_lsu);
        grant_lsu = lsu_req & ~grant_ifu;
        if (grant_ifu) begin
          state_nxt = RD_IFU;
        end else if (grant_lsu) begin
          state_nxt = lsu_awvalid ? WR_LSU : RD_LSU;
        end
      end
      RD_IFU, RD_LSU: begin
        if (r_last_hs) state_nxt = IDLE;
      end
      WR_LSU: begin
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant_lsu <= 1'b1;
      ar_done        <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ifu) begin
        last_grant_lsu <= 1'b0;
      end else if (grant_lsu) begin
        last_grant_lsu <= 1'b1;
      end
      // IDLE always separates two grants, so it is the natural place to clear.
      if (state == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (ar_hs)     ar_done <= 1'b1;
        if (aw_hs)     aw_done <= 1'b1;
        if (w_last_hs) w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_awaddr    = '0;
    m_awid      = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awburst   = '0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    case (state)
      RD_IFU: begin
        m_arvalid   = ifu_arvalid & ~ar_done;
        m_araddr    = ifu_araddr;
        m_arid      = IFU_ID;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arburst   = ifu_arburst;
        ifu_arready = m_arready & ~ar_done;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        m_rready    = ifu_rready;
      end
      RD_LSU: begin
        m_arvalid   = lsu_arvalid & ~ar_done;
        m_araddr    = lsu_araddr;
        m_arid      = LSU_ID;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arburst   = lsu_arburst;
        lsu_arready = m_arready & ~ar_done;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        m_rready    = lsu_rready;
      end
      WR_LSU: begin
        m_awvalid   = lsu_awvalid & ~aw_done;
        m_awaddr    = lsu_awaddr;
        m_awid      = LSU_ID;
        m_awlen     = lsu_awlen;
        m_awsize    = lsu_awsize;
        m_awburst   = lsu_awburst;
        lsu_awready = m_awready & ~aw_done;
        m_wvalid    = lsu_wvalid & ~w_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wlast     = lsu_wlast;
        lsu_wready  = m_wready & ~w_done;
        lsu_bvalid  = m_bvalid;
        lsu_bresp   = m_bresp;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060061_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: transaction-level owner model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_ysyx_23060061_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;

  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;

  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [7:0]  lsu_awlen;
  logic [2:0]  lsu_awsize;
  logic [1:0]  lsu_awburst, lsu_bresp;
  logic [3:0]  lsu_wstrb;

  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_ar_hs = 0;
  int n_aw_hs = 0;
  int n_w_hs = 0;

  ysyx_23060061_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // own: 0 nobody, 1 IFU read, 2 LSU read, 3 LSU write (matches the debug state numbering).
  int own = 0;
  bit last_lsu = 1'b1;
  int ar_cnt = 0;
  int aw_cnt = 0;
  int wl_cnt = 0;

  // Bit order: ifu_arready ifu_rvalid lsu_arready lsu_rvalid lsu_awready lsu_wready
  //            lsu_bvalid m_arvalid m_rready m_awvalid m_wvalid m_bready
  function automatic logic [11:0] act_vr();
    return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
            lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};
  endfunction

  function automatic logic [11:0] exp_vr();
    logic rd_ifu, rd_lsu, wr, src_av, src_rr, ar_open, aw_open, w_open;
    rd_ifu  = (own == 1);
    rd_lsu  = (own == 2);
    wr      = (own == 3);
    src_av  = rd_ifu ? ifu_arvalid : (rd_lsu ? lsu_arvalid : 1'b0);
    src_rr  = rd_ifu ? ifu_rready : (rd_lsu ? lsu_rready : 1'b0);
    ar_open = (ar_cnt == 0);
    aw_open = (aw_cnt == 0);
    w_open  = (wl_cnt == 0);
    return {rd_ifu & m_arready & ar_open, rd_ifu & m_rvalid,
            rd_lsu & m_arready & ar_open, rd_lsu & m_rvalid,
            wr & m_awready & aw_open, wr & m_wready & w_open, wr & m_bvalid,
            (rd_ifu | rd_lsu) & src_av & ar_open, (rd_ifu | rd_lsu) & src_rr,
            wr & lsu_awvalid & aw_open, wr & lsu_wvalid & w_open, wr & lsu_bready};
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [11:0] e;
    if (!rst) begin
      own      <= 0;
      last_lsu <= 1'b1;
      ar_cnt   <= 0;
      aw_cnt   <= 0;
      wl_cnt   <= 0;
    end else begin
      e = exp_vr();
      case (own)
        0: begin
          ar_cnt <= 0;
          aw_cnt <= 0;
          wl_cnt <= 0;
          if (ifu_arvalid && (!(lsu_awvalid || lsu_arvalid) || last_lsu)) begin
            own <= 1; last_lsu <= 1'b0;
          end else if (lsu_awvalid) begin
            own <= 3; last_lsu <= 1'b1;
          end else if (lsu_arvalid) begin
            own <= 2; last_lsu <= 1'b1;
          end
        end
        1, 2: begin
          if (e[4] && m_arready) ar_cnt <= ar_cnt + 1;
          if (m_rvalid && e[3] && m_rlast) own <= 0;
        end
        default: begin
          if (e[2] && m_awready) aw_cnt <= aw_cnt + 1;
          if (e[1] && m_wready && lsu_wlast) wl_cnt <= wl_cnt + 1;
          if (m_bvalid && e[0]) own <= 0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_arvalid && m_arready) n_ar_hs <= n_ar_hs + 1;
      if (m_awvalid && m_awready) n_aw_hs <= n_aw_hs + 1;
      if (m_wvalid && m_wready)   n_w_hs  <= n_w_hs + 1;
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    e = exp_vr();
    chk("valid_ready", {52'd0, act_vr()}, {52'd0, e});
    chk("state", {62'd0, dbg_state}, 64'(own));
    if (e[4]) begin
      if (own == 1)
        chk("ar_fields", {m_araddr, m_arid, m_arlen, m_arsize, m_arburst},
            {ifu_araddr, 4'd0, ifu_arlen, ifu_arsize, ifu_arburst});
      else
        chk("ar_fields", {m_araddr, m_arid, m_arlen, m_arsize, m_arburst},
            {lsu_araddr, 4'd1, lsu_arlen, lsu_arsize, lsu_arburst});
    end
    if (e[10]) chk("ifu_r", {ifu_rdata, ifu_rresp, ifu_rlast}, {m_rdata, m_rresp, m_rlast});
    if (e[8])  chk("lsu_r", {lsu_rdata, lsu_rresp, lsu_rlast}, {m_rdata, m_rresp, m_rlast});
    if (e[2])
      chk("aw_fields", {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst},
          {lsu_awaddr, 4'd1, lsu_awlen, lsu_awsize, lsu_awburst});
    if (e[1]) chk("w_fields", {m_wdata, m_wstrb, m_wlast}, {lsu_wdata, lsu_wstrb, lsu_wlast});
    if (e[5]) chk("lsu_bresp", {62'd0, lsu_bresp}, {62'd0, m_bresp});
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    ifu_rready  = 1;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
    lsu_rready  = 1;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_awlen = '0; lsu_awsize = 3'd2; lsu_awburst = 2'b01;
    lsu_wvalid  = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 0; lsu_bready = 1;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_bid = '0;
  endtask

  initial begin
    int base;
    rst = 1'b0;
    clear_inputs();
    do_reset();
    settle();
    chk("reset_vr", {52'd0, act_vr()}, 64'd0);
    chk("reset_state", {62'd0, dbg_state}, 64'd0);
    tick();

    // 1: IFU single read
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; m_arready = 1;
    settle();
    chk("t1_arvalid_cycle_n", {63'd0, m_arvalid}, 64'd0);
    tick();
    settle();
    chk("t1_arvalid_n1", {63'd0, m_arvalid}, 64'd1);
    chk("t1_arid", {60'd0, m_arid}, 64'd0);
    chk("t1_araddr", {32'd0, m_araddr}, 64'h8000_0000);
    tick();
    ifu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1;
    settle();
    chk("t1_rdata", {32'd0, ifu_rdata}, 64'hDEAD_BEEF);
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    chk("t1_idle", {62'd0, dbg_state}, 64'd0);
    tick();

    // 2: simultaneous IFU and LSU reads right after reset
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
    lsu_arvalid = 1; lsu_araddr = 32'h2000_0000; m_arready = 1;
    tick();
    settle();
    chk("t2_first_id", {60'd0, m_arid}, 64'd0);
    chk("t2_lsu_arready", {63'd0, lsu_arready}, 64'd0);
    tick();
    ifu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'h1111_1111; m_rlast = 1;
    settle();
    chk("t2_lsu_rvalid_blocked", {63'd0, lsu_rvalid}, 64'd0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    chk("t2_gap_arvalid", {63'd0, m_arvalid}, 64'd0);
    tick();
    settle();
    chk("t2_lsu_arid", {60'd0, m_arid}, 64'd1);
    chk("t2_lsu_araddr", {32'd0, m_araddr}, 64'h2000_0000);
    tick();
    lsu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'h2222_2222; m_rlast = 1;
    settle();
    chk("t2_lsu_rdata", {32'd0, lsu_rdata}, 64'h2222_2222);
    chk("t2_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    tick();

    // 3: LSU write, AW accepted two cycles ahead of W
    base = n_aw_hs;
    lsu_awvalid = 1; lsu_awaddr = 32'h1000_0000; lsu_awsize = 3'd0;
    m_awready = 1; m_wready = 1;
    tick();
    settle();
    chk("t3_state", {62'd0, dbg_state}, 64'd3);
    chk("t3_awid", {60'd0, m_awid}, 64'd1);
    tick();
    lsu_awvalid = 0;
    tick();
    lsu_wvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'b0001; lsu_wlast = 1;
    settle();
    chk("t3_wdata", {32'd0, m_wdata}, 64'h41);
    chk("t3_wstrb", {60'd0, m_wstrb}, 64'h1);
    tick();
    lsu_wvalid = 0; lsu_wlast = 0;
    m_bvalid = 1; m_bresp = 2'b00; m_bid = 4'd1;
    settle();
    chk("t3_bvalid", {63'd0, lsu_bvalid}, 64'd1);
    chk("t3_bresp", {62'd0, lsu_bresp}, 64'd0);
    tick();
    m_bvalid = 0;
    settle();
    chk("t3_aw_count", 64'(n_aw_hs - base), 64'd1);
    chk("t3_w_count", 64'(n_w_hs), 64'd1);
    tick();

    // 4: IFU burst of four beats with a two-cycle R stall, SLVERR on beat 1
    ifu_arvalid = 1; ifu_araddr = 32'h8000_1000; ifu_arlen = 8'd3;
    tick();
    tick();
    ifu_arvalid = 0; ifu_arlen = 8'd0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        m_rvalid = 0;
        repeat (2) begin
          settle();
          chk("t4_hold", {62'd0, dbg_state}, 64'd1);
          tick();
        end
      end
      m_rvalid = 1; m_rdata = 32'hA000_0000 + 32'(b); m_rlast = (b == 3);
      m_rresp = (b == 1) ? 2'b10 : 2'b00;
      settle();
      chk("t4_rdata", {32'd0, ifu_rdata}, 64'hA000_0000 + 64'(b));
      chk("t4_state", {62'd0, dbg_state}, 64'd1);
      tick();
    end
    m_rvalid = 0; m_rlast = 0; m_rresp = 2'b00;
    settle();
    chk("t4_idle", {62'd0, dbg_state}, 64'd0);
    tick();

    // 5: crossbar holds off AR for five cycles
    base = n_ar_hs;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_2000; m_arready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_arready_low", {63'd0, ifu_arready}, 64'd0);
      chk("t5_araddr_stable", {32'd0, m_araddr}, 64'h8000_2000);
      tick();
    end
    m_arready = 1;
    settle();
    chk("t5_arready", {63'd0, ifu_arready}, 64'd1);
    tick();
    repeat (2) begin
      settle();
      chk("t5_no_dup", {63'd0, m_arvalid}, 64'd0);
      tick();
    end
    ifu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'h55; m_rlast = 1;
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    chk("t5_ar_count", 64'(n_ar_hs - base), 64'd1);
    tick();

    // 6: reset lands on the second beat of a burst
    ifu_arvalid = 1; ifu_araddr = 32'h8000_4000; ifu_arlen = 8'd1;
    tick();
    tick();
    ifu_arvalid = 0; ifu_arlen = 8'd0;
    m_rvalid = 1; m_rdata = 32'hB0; m_rlast = 0;
    tick();
    m_rdata = 32'hB1; m_rlast = 1;
    #1;
    rst = 1'b0;
    #1;
    chk("t6_vr_zero", {52'd0, act_vr()}, 64'd0);
    chk("t6_state_idle", {62'd0, dbg_state}, 64'd0);
    chk("t6_rdata_zero", {32'd0, ifu_rdata}, 64'd0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    rst = 1'b1;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_3000;
    tick();
    settle();
    chk("t6_regrant", {63'd0, m_arvalid}, 64'd1);
    chk("t6_regrant_addr", {32'd0, m_araddr}, 64'h8000_3000);
    tick();
    ifu_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'hC3; m_rlast = 1;
    settle();
    chk("t6_rdata", {32'd0, ifu_rdata}, 64'hC3);
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    chk("t6_idle", {62'd0, dbg_state}, 64'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_axi_arbiter.md
Name: ysyx_23060061_axi_arbiter

Overview:
- 2:1 AXI4 arbiter between the CPU's instruction-fetch port (IFU, read-only) and its load/store port (LSU, read+write).
- Merges both onto the single AXI4 master port that feeds the crossbar.
- Serialises traffic: exactly one transaction (read burst or write burst) is outstanding at a time.
- IFU/LSU arbitration is round-robin; grants are held until the response handshake completes.

Parameters:
ADDR_W, 32, address width of all AR/AW channels
DATA_W, 32, data width of R/W channels; WSTRB width = DATA_W/8
ID_W, 4, AXI ID width
IFU_ID, 4'd0, ID driven on m_arid for IFU reads
LSU_ID, 4'd1, ID driven on m_arid/m_awid for LSU transactions

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active low
ifu_ar{valid,addr,len,size,burst}  in  1,ADDR_W,8,3,2  IFU read address
ifu_arready  out  1  IFU AR accept
ifu_r{valid,data,resp,last}  out  1,DATA_W,2,1  IFU read data
ifu_rready  in  1  IFU R accept
lsu_ar{valid,addr,len,size,burst}  in  1,ADDR_W,8,3,2  LSU read address
lsu_arready  out  1  LSU AR accept
lsu_r{valid,data,resp,last}  out  1,DATA_W,2,1  LSU read data
lsu_rready  in  1  LSU R accept
lsu_aw{valid,addr,len,size,burst}  in  1,ADDR_W,8,3,2  LSU write address
lsu_awready  out  1  LSU AW accept
lsu_w{valid,data,strb,last}  in  1,DATA_W,DATA_W/8,1  LSU write data
lsu_wready  out  1  LSU W accept
lsu_b{valid,resp}  out  1,2  LSU write response
lsu_bready  in  1  LSU B accept
m_ar{valid,addr,id,len,size,burst}  out  1,ADDR_W,ID_W,8,3,2  to crossbar
m_arready  in  1  crossbar AR accept
m_r{valid,data,resp,last,id}  in  1,DATA_W,2,1,ID_W  from crossbar
m_rready  out  1  R accept to crossbar
m_aw{valid,addr,id,len,size,burst}  out  1,ADDR_W,ID_W,8,3,2  to crossbar
m_awready  in  1  crossbar AW accept
m_w{valid,data,strb,last}  out  1,DATA_W,DATA_W/8,1  to crossbar
m_wready  in  1  crossbar W accept
m_b{valid,resp,id}  in  1,2,ID_W  from crossbar
m_bready  out  1  B accept to crossbar

Behaviour:
- States: IDLE, RD_IFU, RD_LSU, WR_LSU. Reset (rst=0, async) -> IDLE, last_grant=LSU.
- In IDLE, and during reset, all valid/ready outputs = 0.
- IDLE request set: ifu_req=ifu_arvalid; lsu_req=lsu_awvalid|lsu_arvalid.
- Grant: if exactly one of ifu_req/lsu_req is set, grant it. If both, grant the side not equal to last_grant. LSU write takes priority over LSU read.
- Transition is registered: request seen in cycle N -> m_*valid asserted in cycle N+1. last_grant updates on the transition.
- RD_x: m_ar* = source fields, with m_arid = source ID parameter.
  - m_arvalid = src_arvalid & ~ar_done; src_arready = m_arready & ~ar_done.
  - ar_done flag sets on AR handshake; only one AR is forwarded per grant.
  - R channel routed combinationally to the source; m_rready = src_rready.
  - The non-granted source sees all valid/ready = 0.
- Exit RD_x -> IDLE on the cycle m_rvalid & m_rready & m_rlast.
- WR_LSU: AW and W forwarded independently, with aw_done/w_done flags.
  - W beats pass through until the beat with wlast handshakes, which sets w_done.
  - B routed to LSU. Exit -> IDLE on m_bvalid & m_bready.
- R/B arriving while not in the matching state: m_rready/m_bready = 0, response not consumed.
- Back-to-back: after exit, one IDLE cycle minimum before the next grant.
- Response data/resp/last pass through unmodified; m_rid/m_bid are ignored.
- SLVERR/DECERR are forwarded as-is and do not alter the FSM.
- Reset mid-transaction: FSM -> IDLE, all flags cleared, outputs zero in the same cycle; the in-flight burst is abandoned.

Test Plan:
- IFU-only single read addr 0x8000_0000, len 0: m_arvalid at N+1, m_arid=0; crossbar returns rdata 0xDEADBEEF rlast=1 -> ifu_rdata=0xDEADBEEF; FSM back to IDLE next cycle.
- IFU and LSU reads asserted same cycle after reset (last_grant=LSU): IFU served first; LSU AR forwarded with m_arid=1 only after IFU rlast; LSU read then completes.
- LSU write 0x1000_0000, wdata 0x41, strb 4'b0001, AW accepted 2 cycles before W: a single AW and a single W are forwarded; bresp=OKAY routed to lsu_bresp.
- IFU burst len=3: four R beats pass through, with crossbar stalling R for 2 cycles mid-burst; grant held throughout; exit only after 4th beat with rlast.
- m_arready held low 5 cycles: ifu_arready stays 0, m_araddr is stable, no duplicate AR after the eventual accept.
- rst driven low on the second R beat of a burst: all outputs 0 immediately, FSM IDLE; a new IFU request after rst release is granted normally.
